// File: rtl/cache_alloc_pkg.sv
// Shared state encoding and helpers for the cache way allocator and its tag array.
package cache_alloc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WAIT_VICTIM,
    ALLOC
  } alloc_state_e;

  // Widest way vector the helpers handle; callers size-cast to NUM_WAYS.
  localparam int unsigned MAX_WAYS = 64;
  typedef logic [MAX_WAYS-1:0] way_vec_t;

  function automatic way_vec_t lowest_one_hot(input way_vec_t vec);
    return vec & (~vec + way_vec_t'(1));
  endfunction

  function automatic int unsigned tag_width(input int unsigned address_width,
                                            input int unsigned offset_bits);
    return address_width - offset_bits;
  endfunction

endpackage

// File: rtl/cache_way_allocator_if.sv
// Requester, response and replacement-policy signals of cache_way_allocator.
interface cache_way_allocator_if #(
  parameter int unsigned NUM_WAYS      = 4,
  parameter int unsigned ADDRESS_WIDTH = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic                     resp_valid;
  logic                     resp_hit;
  logic [NUM_WAYS-1:0]      resp_way;
  logic [NUM_WAYS-1:0]      hitWay;
  logic [NUM_WAYS-1:0]      allocateWay;
  logic                     victim_req;
  logic [NUM_WAYS-1:0]      evictionTarget;
  logic                     evictionReady;

  modport master (
    output req_valid, req_addr, evictionTarget, evictionReady,
    input  req_ready, resp_valid, resp_hit, resp_way, hitWay, allocateWay, victim_req
  );

  modport slave (
    input  req_valid, req_addr, evictionTarget, evictionReady,
    output req_ready, resp_valid, resp_hit, resp_way, hitWay, allocateWay, victim_req
  );
endinterface

// File: rtl/cache_tag_array.sv
// NUM_WAYS tag/valid registers with a one-hot write port, parallel compare and clear-all.
module cache_tag_array #(
  parameter int unsigned NUM_WAYS  = 4,
  parameter int unsigned TAG_WIDTH = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_wr_en,
  input  logic [NUM_WAYS-1:0]  i_wr_way,
  input  logic [TAG_WIDTH-1:0] i_wr_tag,
  input  logic [TAG_WIDTH-1:0] i_cmp_tag,
  output logic [NUM_WAYS-1:0]  o_match,
  output logic [NUM_WAYS-1:0]  o_valid
);
  logic [TAG_WIDTH-1:0] r_tags [NUM_WAYS];
  logic [NUM_WAYS-1:0]  r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < NUM_WAYS; i++) r_tags[i] <= '0;
    end else if (i_clear) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      for (int unsigned i = 0; i < NUM_WAYS; i++) begin
        if (i_wr_way[i]) begin
          r_tags[i]  <= i_wr_tag;
          r_valid[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_match = '0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      o_match[i] = r_valid[i] && (r_tags[i] == i_cmp_tag);
    end
  end

  assign o_valid = r_valid;
endmodule

// File: rtl/cache_way_allocator.sv
// Tag lookup and way allocation for one fully-associative set, upstream of the LRU policy.
// Optional flush port enabled by defining CACHE_ALLOC_FLUSH_EN.
import cache_alloc_pkg::*;

module cache_way_allocator #(
  parameter int unsigned NUM_WAYS      = 4,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned OFFSET_BITS   = 6
) (
  input logic clk,
  input logic reset,
`ifdef CACHE_ALLOC_FLUSH_EN
  input logic flush,
`endif
  cache_way_allocator_if.slave bus
);
  localparam int unsigned TAG_WIDTH = tag_width(ADDRESS_WIDTH, OFFSET_BITS);

  alloc_state_e         r_state;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [NUM_WAYS-1:0]  r_victim;
  logic                 r_hit;
  logic                 r_resp_valid;
  logic                 r_resp_hit;
  logic                 r_victim_req;
  logic [NUM_WAYS-1:0]  r_resp_way;
  logic [NUM_WAYS-1:0]  r_hit_way;
  logic [NUM_WAYS-1:0]  r_alloc_way;

  logic                 w_flush;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_clear;
  logic                 w_wr_en;
  logic                 w_unused_offset;
  logic [TAG_WIDTH-1:0] w_req_tag;
  logic [NUM_WAYS-1:0]  w_match;
  logic [NUM_WAYS-1:0]  w_valid;
  logic [NUM_WAYS-1:0]  w_first_invalid;
  logic [NUM_WAYS-1:0]  w_target;

`ifdef CACHE_ALLOC_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_req_tag       = bus.req_addr[ADDRESS_WIDTH-1:OFFSET_BITS];
  assign w_unused_offset = ^bus.req_addr[OFFSET_BITS-1:0];
  assign w_ready         = (r_state == IDLE) && !w_flush;
  assign w_accept        = bus.req_valid && w_ready;
  assign w_clear         = (r_state == IDLE) && w_flush;
  assign w_wr_en         = (r_state == ALLOC);
  assign w_first_invalid = NUM_WAYS'(lowest_one_hot(way_vec_t'(~w_valid)));
  assign w_target        = NUM_WAYS'(lowest_one_hot(way_vec_t'(bus.evictionTarget)));

  cache_tag_array #(
    .NUM_WAYS  (NUM_WAYS),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_tags (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_clear),
    .i_wr_en   (w_wr_en),
    .i_wr_way  (r_victim),
    .i_wr_tag  (r_tag),
    .i_cmp_tag (w_req_tag),
    .o_match   (w_match),
    .o_valid   (w_valid)
  );

  // The compare runs on the incoming tag at accept time, so hit outputs are
  // registered then and show during LOOKUP; LOOKUP only routes the miss path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_tag        <= '0;
      r_victim     <= '0;
      r_hit        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_way   <= '0;
      r_hit_way    <= '0;
      r_alloc_way  <= '0;
      r_victim_req <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_way   <= '0;
      r_hit_way    <= '0;
      r_alloc_way  <= '0;
      r_victim_req <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tag    <= w_req_tag;
            r_hit    <= |w_match;
            r_victim <= w_first_invalid;
            r_state  <= LOOKUP;
            if (|w_match) begin
              r_resp_valid <= 1'b1;
              r_resp_hit   <= 1'b1;
              r_resp_way   <= w_match;
              r_hit_way    <= w_match;
            end
          end
        end
        LOOKUP: begin
          if (r_hit) begin
            r_state <= IDLE;
          end else if (|r_victim) begin
            r_state      <= ALLOC;
            r_resp_valid <= 1'b1;
            r_resp_way   <= r_victim;
            r_alloc_way  <= r_victim;
          end else begin
            r_state      <= WAIT_VICTIM;
            r_victim_req <= 1'b1;
          end
        end
        WAIT_VICTIM: begin
          if (bus.evictionReady && |bus.evictionTarget) begin
            r_victim     <= w_target;
            r_state      <= ALLOC;
            r_resp_valid <= 1'b1;
            r_resp_way   <= w_target;
            r_alloc_way  <= w_target;
          end else begin
            r_victim_req <= 1'b1;
          end
        end
        ALLOC:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_hit    = r_resp_hit;
  assign bus.resp_way    = r_resp_way;
  assign bus.hitWay      = r_hit_way;
  assign bus.allocateWay = r_alloc_way;
  assign bus.victim_req  = r_victim_req;
endmodule

// File: tb/tb_cache_way_allocator.sv
// Directed, table-driven bench for cache_way_allocator (flush sequence when CACHE_ALLOC_FLUSH_EN is defined).
module tb_cache_way_allocator;
  logic clk;
  logic reset;
`ifdef CACHE_ALLOC_FLUSH_EN
  logic flush;
`endif

  int checks;
  int failures;

  cache_way_allocator_if #(.NUM_WAYS(4), .ADDRESS_WIDTH(32)) bus ();

  cache_way_allocator #(
    .NUM_WAYS      (4),
    .ADDRESS_WIDTH (32),
    .OFFSET_BITS   (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
`ifdef CACHE_ALLOC_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          dly;
    int          zeros;
    logic [3:0]  tgt;
    logic        hit;
    logic [3:0]  way;
    int          lat;
    int          vic;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One lookup; the policy answers victim requests after dly cycles of
  // evictionReady=0 and zeros cycles of evictionReady=1 with a zero target.
  task automatic run_txn(input string nm, input logic [31:0] addr, input int dly,
                         input int zeros, input logic [3:0] tgt, input logic exp_hit,
                         input logic [3:0] exp_way, input int exp_lat, input int exp_vic);
    int lat, vic, stray;
    bit seen;
    logic act_hit;
    logic [3:0] act_way, act_hw, act_aw;
    lat = 0; vic = 0; stray = 0; seen = 0;
    act_hit = 1'b0; act_way = '0; act_hw = '0; act_aw = '0;
    @(negedge clk);
    chk({nm, " req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      if (bus.resp_valid) begin
        seen    = 1;
        lat     = cyc;
        act_hit = bus.resp_hit;
        act_way = bus.resp_way;
        act_hw  = bus.hitWay;
        act_aw  = bus.allocateWay;
      end else if (bus.hitWay != 4'b0 || bus.allocateWay != 4'b0) begin
        stray++;
      end
      if (bus.victim_req) begin
        vic++;
        if (vic <= dly) begin
          bus.evictionReady  = 1'b0;
          bus.evictionTarget = '0;
        end else if (vic <= dly + zeros) begin
          bus.evictionReady  = 1'b1;
          bus.evictionTarget = '0;
        end else begin
          bus.evictionReady  = 1'b1;
          bus.evictionTarget = tgt;
        end
      end else begin
        bus.evictionReady  = 1'b0;
        bus.evictionTarget = '0;
      end
      if (!seen) @(negedge clk);
    end
    bus.evictionReady  = 1'b0;
    bus.evictionTarget = '0;
    chk({nm, " resp_seen"}, 32'(seen), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " resp_hit"}, 32'(act_hit), 32'(exp_hit));
    chk({nm, " resp_way"}, 32'(act_way), 32'(exp_way));
    chk({nm, " hitWay"}, 32'(act_hw), exp_hit ? 32'(exp_way) : 32'd0);
    chk({nm, " allocateWay"}, 32'(act_aw), exp_hit ? 32'd0 : 32'(exp_way));
    chk({nm, " victim_cycles"}, 32'(vic), 32'(exp_vic));
    chk({nm, " stray_pulses"}, 32'(stray), 32'd0);
    @(negedge clk);
    chk({nm, " pulse_end"},
        32'({bus.resp_valid, bus.hitWay, bus.allocateWay, bus.victim_req}), 32'd0);
  endtask

  initial begin
    int stray;
    bit got;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.evictionReady = 1'b0;
    bus.evictionTarget = '0;
`ifdef CACHE_ALLOC_FLUSH_EN
    flush = 1'b0;
`endif

    //                   addr          dly zr tgt      hit   way     lat vic
    tbl[0]  = '{32'h0000_0040, 0, 0, 4'b0000, 1'b0, 4'b0001, 2, 0};
    tbl[1]  = '{32'h0000_0080, 0, 0, 4'b0000, 1'b0, 4'b0010, 2, 0};
    tbl[2]  = '{32'h0000_00C0, 0, 0, 4'b0000, 1'b0, 4'b0100, 2, 0};
    tbl[3]  = '{32'h0000_0100, 0, 0, 4'b0000, 1'b0, 4'b1000, 2, 0};
    tbl[4]  = '{32'h0000_007F, 0, 0, 4'b0000, 1'b1, 4'b0001, 1, 0};
    tbl[5]  = '{32'h0000_0100, 0, 0, 4'b0000, 1'b1, 4'b1000, 1, 0};
    tbl[6]  = '{32'h0000_0140, 3, 0, 4'b0100, 1'b0, 4'b0100, 6, 4};
    tbl[7]  = '{32'h0000_00C0, 0, 0, 4'b0110, 1'b0, 4'b0010, 3, 1};
    tbl[8]  = '{32'h0000_017F, 0, 0, 4'b0000, 1'b1, 4'b0100, 1, 0};
    tbl[9]  = '{32'h0000_0080, 1, 2, 4'b1000, 1'b0, 4'b1000, 6, 4};
    tbl[10] = '{32'h0000_0100, 0, 0, 4'b1111, 1'b0, 4'b0001, 3, 1};
    tbl[11] = '{32'h0000_0040, 0, 0, 4'b1100, 1'b0, 4'b0100, 3, 1};
    tbl[12] = '{32'h0000_0080, 0, 0, 4'b0000, 1'b1, 4'b1000, 1, 0};
    tbl[13] = '{32'h0000_00C0, 0, 0, 4'b0000, 1'b1, 4'b0010, 1, 0};
    tbl[14] = '{32'h0000_0040, 0, 0, 4'b0000, 1'b1, 4'b0100, 1, 0};
    tbl[15] = '{32'h0000_0100, 0, 0, 4'b0000, 1'b1, 4'b0001, 1, 0};
    tbl[16] = '{32'hFFFF_FFC0, 0, 0, 4'b0001, 1'b0, 4'b0001, 3, 1};
    tbl[17] = '{32'hFFFF_FFFF, 0, 0, 4'b0000, 1'b1, 4'b0001, 1, 0};

    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_hit", 32'(bus.resp_hit), 32'd0);
    chk("rst resp_way", 32'(bus.resp_way), 32'd0);
    chk("rst hitWay", 32'(bus.hitWay), 32'd0);
    chk("rst allocateWay", 32'(bus.allocateWay), 32'd0);
    chk("rst victim_req", 32'(bus.victim_req), 32'd0);
    reset = 1'b0;

    run_txn("first_miss", 32'h0000_1040, 0, 0, 4'b0000, 1'b0, 4'b0001, 2, 0);
    run_txn("first_hit", 32'h0000_1040, 0, 0, 4'b0000, 1'b1, 4'b0001, 1, 0);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].addr, tbl[i].dly, tbl[i].zeros, tbl[i].tgt,
              tbl[i].hit, tbl[i].way, tbl[i].lat, tbl[i].vic);
    end

    // Set is full: park in WAIT_VICTIM, then reset asynchronously.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_01C0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (bus.victim_req) got = 1;
      else @(negedge clk);
    end
    chk("rstwait victim_req", 32'(got), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstwait async victim_req", 32'(bus.victim_req), 32'd0);
    chk("rstwait async req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.hitWay != 4'b0 || bus.allocateWay != 4'b0 || bus.victim_req)
        stray++;
    end
    chk("rstwait no_pulses", 32'(stray), 32'd0);
    run_txn("rstwait old_hit_misses", 32'h0000_0040, 0, 0, 4'b0000, 1'b0, 4'b0001, 2, 0);

`ifdef CACHE_ALLOC_FLUSH_EN
    run_txn("fl fill2", 32'h0000_0080, 0, 0, 4'b0000, 1'b0, 4'b0010, 2, 0);
    run_txn("fl fill3", 32'h0000_00C0, 0, 0, 4'b0000, 1'b0, 4'b0100, 2, 0);
    run_txn("fl fill4", 32'h0000_0100, 0, 0, 4'b0000, 1'b0, 4'b1000, 2, 0);
    run_txn("fl hit1", 32'h0000_0040, 0, 0, 4'b0000, 1'b1, 4'b0001, 1, 0);
    @(negedge clk);
    flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0240;
    #1;
    chk("fl req_ready_low", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    bus.req_valid = 1'b0;
    chk("fl not_accepted", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    chk("fl no_resp", 32'({bus.resp_valid, bus.victim_req}), 32'd0);
    run_txn("fl miss_after", 32'h0000_0080, 0, 0, 4'b0000, 1'b0, 4'b0001, 2, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_way_allocator.md
# cache_way_allocator

Tag-lookup and way-allocation stage for a fully-associative cache set; sits directly upstream of the LRU eviction policy. Accepts lookup requests, compares the request tag against NUM_WAYS stored tags, and reports hit/miss to the requester. On a hit it pulses the one-hot `hitWay` to the policy. On a miss it fills an invalid way, or takes the policy's `evictionTarget`, writes the new tag, and pulses the one-hot `allocateWay`.

## Interface
- NUM_WAYS, 4: number of ways. Width of all one-hot way vectors.
- ADDRESS_WIDTH, 32: request address width.
- OFFSET_BITS, 6: line-offset bits dropped from the address. TAG_WIDTH = ADDRESS_WIDTH - OFFSET_BITS.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  high only in IDLE (and not flushing).
- req_addr  in  ADDRESS_WIDTH  request address; tag = req_addr[ADDRESS_WIDTH-1:OFFSET_BITS].
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  1 = hit, 0 = miss-allocated. Valid with resp_valid.
- resp_way  out  NUM_WAYS  one-hot way hit or allocated. Valid with resp_valid.
- hitWay  out  NUM_WAYS  one-cycle one-hot pulse to the policy on a hit.
- allocateWay  out  NUM_WAYS  one-cycle one-hot pulse to the policy on allocation.
- victim_req  out  1  high while waiting for a policy victim.
- evictionTarget  in  NUM_WAYS  policy victim, one-hot.
- evictionReady  in  1  evictionTarget is valid.
- flush  in  1  invalidate all ways. Present only with CACHE_ALLOC_FLUSH_EN.

## Operation
- FSM states: IDLE, LOOKUP, WAIT_VICTIM, ALLOC.
- Reset state: IDLE. All valid bits 0, tags 0.
- Reset values of outputs: req_ready=1; resp_valid, resp_hit, victim_req = 0; resp_way, hitWay, allocateWay = 0.
- IDLE: req_valid && req_ready latches the tag, then goes to LOOKUP.
- LOOKUP: match[i] = valid[i] && tag[i]==latched tag.
  - Any match: pulse resp_valid, resp_hit=1, resp_way=match, hitWay=match. Return to IDLE.
  - No match, some way invalid: victim = lowest-index invalid way. Go to ALLOC.
  - No match, all ways valid: go to WAIT_VICTIM.
- WAIT_VICTIM: victim_req=1. When evictionReady=1, latch evictionTarget and go to ALLOC.
  - A non-one-hot evictionTarget is reduced to its lowest set bit.
  - An all-zero evictionTarget is ignored; the block keeps waiting.
- ALLOC: write the tag into the victim way and set its valid bit. Pulse allocateWay=victim, resp_valid, resp_hit=0, resp_way=victim. Return to IDLE.
- Invariant: at most one match bit set. Allocation happens only on a miss, so duplicate tags cannot occur.
- Reset asserted mid-operation: the FSM returns to IDLE and all valid bits clear immediately. No pulses are emitted.

## Timing
- Request accepted on cycle N.
- Hit: resp_valid and hitWay at N+1.
- Miss to an invalid way: resp_valid and allocateWay at N+2.
- Miss with all ways valid: victim_req from N+2. If evictionReady is first sampled high at cycle M ≥ N+2, resp_valid and allocateWay occur at M+1.
- hitWay and allocateWay are never asserted in the same cycle.
- Back-to-back throughput: one request per 2 cycles on hits.
- All outputs are registered or decoded from state; there are no combinational input-to-output paths except req_ready from flush.

## Configuration
- CACHE_ALLOC_FLUSH_EN defined:
  - The flush port exists.
  - flush=1 in IDLE forces req_ready=0 and clears all valid bits at the next edge. The request is not accepted that cycle.
  - flush outside IDLE is ignored; the requester holds it until it takes effect.
- CACHE_ALLOC_FLUSH_EN undefined: the flush port is absent. Valid bits clear only on reset.

## Structure
- Shared package cache_alloc_pkg holds:
  - state enum alloc_state_e.
  - function lowest_one_hot(vec) returning the lowest set bit as one-hot.
  - TAG_WIDTH derivation helper.
- One sub-module: cache_tag_array, holding NUM_WAYS tag and valid registers.
  - Write port: one-hot way + tag.
  - Parallel compare output: match vector.
  - Clear-all input.

## Test plan
- After reset, lookup addr 0x0000_1040 → miss; allocateWay=4'b0001 and resp_way=4'b0001 at N+2; repeat lookup → hit, hitWay=4'b0001 at N+1.
- Fill tags 0x1, 0x2, 0x3, 0x4 (addr<<6) → allocations to ways 0001, 0010, 0100, 1000 in order; victim_req never asserted.
- Full set, new tag 0x5 with evictionReady held low 3 cycles, then evictionTarget=4'b0100 → victim_req high for 4 cycles; allocateWay=4'b0100 one cycle after ready; tag 0x3 now misses.
- evictionTarget=4'b0110 with evictionReady=1 → allocateWay=4'b0010.
- Reset asserted in WAIT_VICTIM → req_ready=1, no pulses; prior hit tag 0x1 now misses and allocates way 4'b0001.
- With CACHE_ALLOC_FLUSH_EN: flush in IDLE with 4 valid ways → next lookup of tag 0x2 misses and allocates way 4'b0001.
